// File: rtl/chronos_runtime_config.sv
// Runtime configuration register file for Chronos.
// The host writes a shadow copy over a simple register bus. A commit request
// copies shadow to active, but only once the accelerator reports quiescence.
// The active copy drives the cfg_* outputs that fan out to every tile.
module chronos_runtime_config #(
    parameter int N_TILES           = 1,
    parameter int ADDR_WIDTH        = 8,
    parameter int DATA_WIDTH        = 32,
    parameter int VERSION           = 10,
    parameter int LOG_CQ_SLICE_SIZE = 10,
    parameter int LOG_GVT_PERIOD    = 5
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         reg_wvalid,
    output logic                         reg_wready,
    input  logic [ADDR_WIDTH-1:0]        reg_waddr,
    input  logic [DATA_WIDTH-1:0]        reg_wdata,
    input  logic                         reg_arvalid,
    input  logic [ADDR_WIDTH-1:0]        reg_araddr,
    output logic                         reg_rvalid,
    output logic [DATA_WIDTH-1:0]        reg_rdata,
    input  logic                         quiesce,
    output logic [LOG_CQ_SLICE_SIZE:0]   cfg_cq_size,
    output logic [3:0]                   cfg_gvt_log_period,
    output logic [N_TILES-1:0]           cfg_log_mask,
    output logic [N_TILES-1:0]           cfg_stats_mask,
    output logic [N_TILES-1:0]           cfg_tile_en,
    output logic                         cfg_update
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int CQ_W  = LOG_CQ_SLICE_SIZE + 1;

    localparam logic [IDX_W-1:0] IDX_VERSION = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_NTILES  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_CQ      = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_GVT     = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_LOG     = IDX_W'(5);
    localparam logic [IDX_W-1:0] IDX_STATS   = IDX_W'(6);
    localparam logic [IDX_W-1:0] IDX_TILE    = IDX_W'(7);
    localparam logic [IDX_W-1:0] IDX_COUNT   = IDX_W'(8);

    localparam logic [DATA_WIDTH-1:0] CQ_MAX   = DATA_WIDTH'(1) << LOG_CQ_SLICE_SIZE;
    localparam logic [CQ_W-1:0]       CQ_RESET = CQ_W'(1) << LOG_CQ_SLICE_SIZE;
    localparam logic [CQ_W-1:0]       CQ_ONE   = CQ_W'(1);
    localparam logic [3:0]            GVT_RESET = 4'(LOG_GVT_PERIOD);
    localparam logic [N_TILES-1:0]    MASK_ONE  = N_TILES'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_APPLY
    } state_t;

    state_t state_reg, state_next;
    logic   apply;
    logic   wr_fire;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    logic [CQ_W-1:0]    cq_shadow_reg;
    logic [3:0]         gvt_shadow_reg;
    logic [N_TILES-1:0] log_shadow_reg;
    logic [N_TILES-1:0] stats_shadow_reg;
    logic [N_TILES-1:0] tile_shadow_reg;

    logic [CQ_W-1:0]    cq_active_reg;
    logic [3:0]         gvt_active_reg;
    logic [N_TILES-1:0] log_active_reg;
    logic [N_TILES-1:0] stats_active_reg;
    logic [N_TILES-1:0] tile_active_reg;
    logic               update_reg;
    logic [31:0]        commit_count_reg;

    logic [CQ_W-1:0]       cq_wr_value;
    logic [3:0]            gvt_wr_value;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    // Byte-offset bits are ignored: the bus is word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{reg_waddr[1:0], reg_araddr[1:0]};

    assign wr_idx  = reg_waddr[ADDR_WIDTH-1:2];
    assign rd_idx  = reg_araddr[ADDR_WIDTH-1:2];
    assign wr_fire = reg_wvalid && reg_wready;

    // Commit FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Commit FSM next state; the shadow copy is writable only while idle.
    always_comb begin
        state_next = state_reg;
        reg_wready = 1'b0;
        apply      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                reg_wready = 1'b1;
                if (reg_wvalid && wr_idx == IDX_CTRL && reg_wdata[0])
                    state_next = ST_PENDING;
            end
            ST_PENDING: begin
                if (quiesce) state_next = ST_APPLY;
            end
            ST_APPLY: begin
                apply      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Clamp incoming CQ size and GVT period into their legal ranges.
    always_comb begin
        cq_wr_value = reg_wdata[CQ_W-1:0];
        if (reg_wdata > CQ_MAX)     cq_wr_value = CQ_RESET;
        else if (reg_wdata == '0)   cq_wr_value = CQ_ONE;
        gvt_wr_value = (reg_wdata[3:0] == 4'd0) ? 4'd1 : reg_wdata[3:0];
    end

    // Shadow register file written by the host.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cq_shadow_reg    <= CQ_RESET;
            gvt_shadow_reg   <= GVT_RESET;
            log_shadow_reg   <= MASK_ONE;
            stats_shadow_reg <= MASK_ONE;
            tile_shadow_reg  <= '1;
        end else if (wr_fire) begin
            case (wr_idx)
                IDX_CQ:    cq_shadow_reg    <= cq_wr_value;
                IDX_GVT:   gvt_shadow_reg   <= gvt_wr_value;
                IDX_LOG:   log_shadow_reg   <= reg_wdata[N_TILES-1:0];
                IDX_STATS: stats_shadow_reg <= reg_wdata[N_TILES-1:0];
                IDX_TILE:  tile_shadow_reg  <= reg_wdata[N_TILES-1:0];
                default: ;
            endcase
        end
    end

    // Active copy: loaded from shadow on the edge leaving APPLY.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cq_active_reg    <= CQ_RESET;
            gvt_active_reg   <= GVT_RESET;
            log_active_reg   <= MASK_ONE;
            stats_active_reg <= MASK_ONE;
            tile_active_reg  <= '1;
            update_reg       <= 1'b0;
            commit_count_reg <= '0;
        end else begin
            update_reg <= apply;
            if (apply) begin
                cq_active_reg    <= cq_shadow_reg;
                gvt_active_reg   <= gvt_shadow_reg;
                log_active_reg   <= log_shadow_reg;
                stats_active_reg <= stats_shadow_reg;
                tile_active_reg  <= tile_shadow_reg;
                commit_count_reg <= commit_count_reg + 32'd1;
            end
        end
    end

    // Read mux; RW registers return the shadow value.
    always_comb begin
        rd_value = '0;
        case (rd_idx)
            IDX_VERSION: rd_value = DATA_WIDTH'(VERSION);
            IDX_NTILES:  rd_value = DATA_WIDTH'(N_TILES);
            IDX_CTRL:    rd_value = DATA_WIDTH'({(state_reg != ST_IDLE), 1'b0});
            IDX_CQ:      rd_value = DATA_WIDTH'(cq_shadow_reg);
            IDX_GVT:     rd_value = DATA_WIDTH'(gvt_shadow_reg);
            IDX_LOG:     rd_value = DATA_WIDTH'(log_shadow_reg);
            IDX_STATS:   rd_value = DATA_WIDTH'(stats_shadow_reg);
            IDX_TILE:    rd_value = DATA_WIDTH'(tile_shadow_reg);
            IDX_COUNT:   rd_value = DATA_WIDTH'(commit_count_reg);
            default:     rd_value = '0;
        endcase
    end

    // Registered read response, one cycle after the request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= reg_arvalid;
            if (reg_arvalid) rdata_reg <= rd_value;
        end
    end

    assign reg_rvalid         = rvalid_reg;
    assign reg_rdata          = rdata_reg;
    assign cfg_cq_size        = cq_active_reg;
    assign cfg_gvt_log_period = gvt_active_reg;
    assign cfg_log_mask       = log_active_reg;
    assign cfg_stats_mask     = stats_active_reg;
    assign cfg_tile_en        = tile_active_reg;
    assign cfg_update         = update_reg;

endmodule

// File: tb/tb_chronos_runtime_config.sv
// Bench for chronos_runtime_config: directed register traffic with a read
// scoreboard and direct checks of the commit timing on the cfg_* outputs.
module tb_chronos_runtime_config;
    localparam int N_TILES = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        reg_wvalid = 1'b0;
    logic        reg_wready;
    logic [7:0]  reg_waddr = '0;
    logic [31:0] reg_wdata = '0;
    logic        reg_arvalid = 1'b0;
    logic [7:0]  reg_araddr = '0;
    logic        reg_rvalid;
    logic [31:0] reg_rdata;
    logic        quiesce = 1'b0;
    logic [10:0] cfg_cq_size;
    logic [3:0]  cfg_gvt_log_period;
    logic [N_TILES-1:0] cfg_log_mask;
    logic [N_TILES-1:0] cfg_stats_mask;
    logic [N_TILES-1:0] cfg_tile_en;
    logic        cfg_update;

    chronos_runtime_config #(
        .N_TILES(N_TILES), .ADDR_WIDTH(8), .DATA_WIDTH(32), .VERSION(10),
        .LOG_CQ_SLICE_SIZE(10), .LOG_GVT_PERIOD(5)
    ) dut (
        .clk(clk), .rstn(rstn),
        .reg_wvalid(reg_wvalid), .reg_wready(reg_wready),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_arvalid(reg_arvalid), .reg_araddr(reg_araddr),
        .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata),
        .quiesce(quiesce),
        .cfg_cq_size(cfg_cq_size), .cfg_gvt_log_period(cfg_gvt_log_period),
        .cfg_log_mask(cfg_log_mask), .cfg_stats_mask(cfg_stats_mask),
        .cfg_tile_en(cfg_tile_en), .cfg_update(cfg_update)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    logic ar_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", name, act);
        end
    endtask

    // Remember whether a read was issued on the last edge.
    always @(posedge clk) ar_d <= reg_arvalid;

    // Monitor: check rvalid timing and pop the scoreboard on each response.
    always @(negedge clk) begin
        if (reg_rvalid === 1'b1 || ar_d === 1'b1)
            check("rvalid_timing", {31'b0, reg_rvalid}, {31'b0, ar_d});
        if (reg_rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL sb_unexpected: got 0x%08h, expected no response", reg_rdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, reg_rdata, e.exp);
            end
        end
    end

    task automatic rd(input int idx, input logic [31:0] exp, input string name);
        exp_t e;
        @(posedge clk); #1;
        reg_arvalid = 1'b1;
        reg_araddr  = 8'(idx << 2);
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk); #1;
        reg_arvalid = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        int n;
        n = 0;
        @(posedge clk); #1;
        reg_wvalid = 1'b1;
        reg_waddr  = 8'(idx << 2);
        reg_wdata  = data;
        @(negedge clk);
        while (reg_wready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (reg_wready !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL wr_timeout: idx %0d wready=%b, required 1", idx, reg_wready);
        end
        @(posedge clk); #1;
        reg_wvalid = 1'b0;
        $display("[TB] write idx %0d data 0x%08h", idx, data);
    endtask

    task automatic check_reset_cfg(input string tag);
        check({tag, "_cfg_cq"},     32'(cfg_cq_size), 32'd1024);
        check({tag, "_cfg_gvt"},    32'(cfg_gvt_log_period), 32'd5);
        check({tag, "_cfg_log"},    32'(cfg_log_mask), 32'h1);
        check({tag, "_cfg_stats"},  32'(cfg_stats_mask), 32'h1);
        check({tag, "_cfg_tile"},   32'(cfg_tile_en), 32'hF);
        check({tag, "_cfg_update"}, 32'(cfg_update), 32'd0);
    endtask

    initial begin
        // Reset and read-only registers.
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_reset_cfg("reset");
        check("reset_rvalid", 32'(reg_rvalid), 32'd0);
        check("reset_rdata", reg_rdata, 32'd0);
        check("reset_wready", 32'(reg_wready), 32'd1);
        rd(0, 32'd10, "rd_version");
        rd(1, 32'd4,  "rd_ntiles");
        rd(2, 32'd0,  "rd_ctrl_reset");
        rd(8, 32'd0,  "rd_count_reset");

        // Shadow clamping.
        wr(3, 32'd5000); rd(3, 32'd1024, "rd_cq_clamp_hi");
        wr(3, 32'd1025); rd(3, 32'd1024, "rd_cq_clamp_1025");
        wr(3, 32'd0);    rd(3, 32'd1,    "rd_cq_clamp_zero");
        wr(4, 32'h13);   rd(4, 32'd3,    "rd_gvt_trunc");
        wr(4, 32'h10);   rd(4, 32'd1,    "rd_gvt_zero");
        wr(4, 32'h3);    rd(4, 32'd3,    "rd_gvt_3");
        @(negedge clk);
        check("shadow_only_cfg_cq", 32'(cfg_cq_size), 32'd1024);
        check("shadow_only_cfg_gvt", 32'(cfg_gvt_log_period), 32'd5);

        // Commit held off while not quiescent.
        quiesce = 1'b0;
        wr(7, 32'h0);
        wr(2, 32'h1);
        @(negedge clk);
        check("pending_wready", 32'(reg_wready), 32'd0);
        rd(2, 32'd2, "rd_ctrl_pending");
        @(posedge clk); #1;
        reg_wvalid = 1'b1;
        reg_waddr  = 8'(5 << 2);
        reg_wdata  = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("pending_write_blocked", 32'(reg_wready), 32'd0);
        end
        @(posedge clk); #1;
        reg_wvalid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("pending_cfg_tile_held", 32'(cfg_tile_en), 32'hF);
        check("pending_no_update", 32'(cfg_update), 32'd0);
        @(posedge clk); #1;
        quiesce = 1'b1;
        @(negedge clk); check("q_rise_c0_update", 32'(cfg_update), 32'd0);
        @(negedge clk); check("q_rise_c1_update", 32'(cfg_update), 32'd0);
                        check("q_rise_c1_tile",   32'(cfg_tile_en), 32'hF);
        @(negedge clk); check("q_rise_c2_update", 32'(cfg_update), 32'd1);
                        check("q_rise_c2_tile",   32'(cfg_tile_en), 32'h0);
                        check("q_rise_c2_cq",     32'(cfg_cq_size), 32'd1);
                        check("q_rise_c2_gvt",    32'(cfg_gvt_log_period), 32'd3);
        @(negedge clk); check("q_rise_c3_update", 32'(cfg_update), 32'd0);
        rd(8, 32'd1, "rd_count_1");
        rd(2, 32'd0, "rd_ctrl_done");
        rd(5, 32'd1, "rd_log_unchanged");

        // Commit with quiesce already high: two cycles to the active copy.
        wr(4, 32'd7);
        wr(2, 32'h1);
        @(negedge clk); check("fast_c0_gvt", 32'(cfg_gvt_log_period), 32'd3);
                        check("fast_c0_update", 32'(cfg_update), 32'd0);
        @(negedge clk); check("fast_c1_gvt", 32'(cfg_gvt_log_period), 32'd3);
                        check("fast_c1_update", 32'(cfg_update), 32'd0);
        @(negedge clk); check("fast_c2_gvt", 32'(cfg_gvt_log_period), 32'd7);
                        check("fast_c2_update", 32'(cfg_update), 32'd1);
        @(negedge clk); check("fast_c3_update", 32'(cfg_update), 32'd0);
        rd(8, 32'd2, "rd_count_2");

        // Reset while a commit is pending.
        quiesce = 1'b0;
        wr(3, 32'd64);
        wr(2, 32'h1);
        rd(2, 32'd2, "rd_ctrl_pending2");
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check_reset_cfg("rst_pend");
        quiesce = 1'b1;
        @(negedge clk); check("rst_pend_update_1", 32'(cfg_update), 32'd0);
        @(negedge clk); check("rst_pend_update_2", 32'(cfg_update), 32'd0);
        rd(2, 32'd0,    "rd_ctrl_after_rst");
        rd(3, 32'd1024, "rd_cq_after_rst");
        rd(8, 32'd0,    "rd_count_after_rst");
        @(negedge clk); check("rst_pend_update_3", 32'(cfg_update), 32'd0);

        // Mask truncation, RO and unmapped writes.
        wr(5, 32'hFF);   rd(5, 32'hF, "rd_log_mask_trunc");
        wr(6, 32'hA5);   rd(6, 32'h5, "rd_stats_mask_trunc");
        wr(0, 32'd123);
        wr(12, 32'd55);
        rd(0, 32'd10, "rd_version_ro");
        rd(12, 32'd0, "rd_unmapped");
        rd(1, 32'd4,  "rd_ntiles_ro");

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
